// File: rtl/csa_resolver_pkg.sv
// Shared constants and FSM state type for the carry-save resolver.
package csa_resolver_pkg;
  localparam int WORD_W    = 32;
  localparam int RES_CHUNK = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } res_state_t;
endpackage

// File: rtl/csa_resolver_if.sv
// Valid/ready bundle between the compressor tree, the resolver and the round-state registers.
interface csa_resolver_if
  import csa_resolver_pkg::*;
#(
  parameter int WIDTH = WORD_W
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_sum;
  logic [WIDTH-1:0] in_carry;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic             out_ovf;

  modport master (
    output in_valid, in_sum, in_carry, out_ready,
    input  in_ready, out_valid, out_result, out_ovf
  );

  modport slave (
    input  in_valid, in_sum, in_carry, out_ready,
    output in_ready, out_valid, out_result, out_ovf
  );
endinterface

// File: rtl/csa_resolver_cpa_chunk.sv
// Narrow ripple-carry adder resolving one CHUNK-bit slice per cycle.
module cpa_chunk #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout
);
  logic [CHUNK:0] c_s;

  assign c_s[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]     = a[i] ^ b[i] ^ c_s[i];
    assign c_s[i+1] = (a[i] & b[i]) | (c_s[i] & (a[i] ^ b[i]));
  end

  assign cout = c_s[CHUNK];
endmodule

// File: rtl/csa_resolver.sv
// Resolves a (sum, carry) redundant pair to one binary word, CHUNK bits per cycle.
module csa_resolver
  import csa_resolver_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int CHUNK = RES_CHUNK
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           flush,
  csa_resolver_if.slave  bus
);
  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = $clog2(NCHUNK) + 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  if (WIDTH % CHUNK != 0) begin : g_bad_chunk
    $error("csa_resolver: WIDTH must be a multiple of CHUNK");
  end

  res_state_t       state_q, state_d, fsm_nxt_s;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, res_q, res_d, result_q, result_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             hi_q, hi_d, c_q, c_d, ovf_q, ovf_d;

  logic [31:0]      sh_s;
  logic [CHUNK-1:0] a_chunk_s, b_chunk_s, sum_chunk_s;
  logic             cout_s;
  logic [WIDTH-1:0] res_merge_s;

  assign sh_s        = 32'(idx_q) * 32'(CHUNK);
  assign a_chunk_s   = CHUNK'(a_q >> sh_s);
  assign b_chunk_s   = CHUNK'(b_q >> sh_s);
  assign res_merge_s = (res_q & ~(CHUNK_MASK << sh_s)) | (WIDTH'(sum_chunk_s) << sh_s);

  cpa_chunk #(.CHUNK(CHUNK)) u_cpa (
    .a    (a_chunk_s),
    .b    (b_chunk_s),
    .cin  (c_q),
    .s    (sum_chunk_s),
    .cout (cout_s)
  );

  // Next-state and datapath update; flush overrides the FSM transition.
  always_comb begin
    fsm_nxt_s = state_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_d      = hi_q;
    res_d     = res_q;
    idx_d     = idx_q;
    c_d       = c_q;
    result_d  = result_q;
    ovf_d     = ovf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && !flush) begin
          fsm_nxt_s = RUN;
          a_d       = bus.in_sum;
          b_d       = {bus.in_carry[WIDTH-2:0], 1'b0};
          hi_d      = bus.in_carry[WIDTH-1];
          idx_d     = '0;
          c_d       = 1'b0;
        end else begin
          fsm_nxt_s = IDLE;
        end
      end
      RUN: begin
        res_d = res_merge_s;
        c_d   = cout_s;
        idx_d = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          fsm_nxt_s = DONE;
          result_d  = res_merge_s;
          ovf_d     = hi_q | cout_s;
        end else begin
          fsm_nxt_s = RUN;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          fsm_nxt_s = IDLE;
        end else begin
          fsm_nxt_s = DONE;
        end
      end
      default: begin
        fsm_nxt_s = IDLE;
      end
    endcase
    state_d = flush ? IDLE : fsm_nxt_s;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      hi_q     <= 1'b0;
      res_q    <= '0;
      idx_q    <= '0;
      c_q      <= 1'b0;
      result_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_q     <= hi_d;
      res_q    <= res_d;
      idx_q    <= idx_d;
      c_q      <= c_d;
      result_q <= result_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.in_ready   = (state_q == IDLE);
  assign bus.out_valid  = (state_q == DONE);
  assign bus.out_result = result_q;
  assign bus.out_ovf    = ovf_q;
endmodule
